// File: rtl/rll_key_pkg.sv
// Shared types and helpers for the RLL32 key loader.
// Latency: none (types, constants and a combinational parity helper only).
// Backpressure: not applicable.
package rll_key_pkg;

   localparam int RLL_KEY_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHIFT = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } rll_key_state_t;

   // Returns 1 when key plus parity bit has odd weight, i.e. even parity is broken.
   function automatic logic rll_key_parity_bad(input logic [RLL_KEY_W-1:0] key,
                                               input logic                 par);
      return (^key) ^ par;
   endfunction

endpackage

// File: rtl/rll_key_shreg.sv
// Shadow key register with a bit counter; bit k is written to shadow[k].
// Latency: one cycle per accepted bit.
// Backpressure: writes are dropped once full; the caller owns flow control.
module rll_key_shreg
   import rll_key_pkg::*;
#(
   parameter int KEY_W = RLL_KEY_W,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_wr_en,
   input  logic             i_wr_bit,
   output logic [KEY_W-1:0] o_shadow,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_full
);

   localparam int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

   logic [KEY_W-1:0] r_shadow;
   logic [CNT_W-1:0] r_cnt;
   logic             w_full;

   assign w_full = (r_cnt == CNT_W'(KEY_W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= '0;
         r_cnt    <= '0;
      end else if (i_clr) begin
         r_shadow <= '0;
         r_cnt    <= '0;
      end else if (i_wr_en && !w_full) begin
         r_shadow[r_cnt[IDX_W-1:0]] <= i_wr_bit;
         r_cnt                      <= r_cnt + 1'b1;
      end
   end

   assign o_shadow = r_shadow;
   assign o_cnt    = r_cnt;
   assign o_full   = w_full;

endmodule

// File: rtl/rll_key_loader.sv
// Serial-to-parallel key loader committing a KEY_W key atomically onto keyIn_0_*; parity check under RLL_KEY_PARITY_EN.
// Latency: load_start to key_valid is KEY_W+2 cycles (KEY_W+3 with parity) with continuous valid.
// Backpressure: key_sdi_ready is a pure decode of the state register; key_sdi_valid low stalls the load.
module rll_key_loader
   import rll_key_pkg::*;
#(
   parameter int KEY_W = RLL_KEY_W,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_start,
   input  logic             key_clr,
   input  logic             key_sdi,
   input  logic             key_sdi_valid,
   output logic             key_sdi_ready,
   output logic [KEY_W-1:0] key_out,
   output logic             key_valid,
   output logic             busy,
   output logic             key_err
);

   rll_key_state_t   r_state;
   rll_key_state_t   w_state_nxt;
   logic [KEY_W-1:0] r_key_out;
   logic             r_key_valid;
   logic [KEY_W-1:0] w_shadow;
   logic [CNT_W-1:0] w_cnt;
   logic             w_full;
   logic             w_rdy;
   logic             w_busy;
   logic             w_accept;
   logic             w_last;
   logic             w_idle_like;
   logic             w_sh_clr;
   logic             w_commit;
   logic             w_chk_bad;

   assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
   assign w_accept    = w_rdy && key_sdi_valid;

   rll_key_shreg #(
      .KEY_W (KEY_W),
      .CNT_W (CNT_W)
   ) u_shreg (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clr    (w_sh_clr),
      .i_wr_en  (w_accept),
      .i_wr_bit (key_sdi),
      .o_shadow (w_shadow),
      .o_cnt    (w_cnt),
      .o_full   (w_full)
   );

`ifdef RLL_KEY_PARITY_EN
   logic r_par;
   logic r_key_err;

   // The parity bit rides one slot past the data bits, after the shadow is full.
   assign w_last    = (w_cnt == CNT_W'(KEY_W));
   assign w_chk_bad = rll_key_parity_bad(RLL_KEY_W'(w_shadow), r_par);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_par     <= 1'b0;
         r_key_err <= 1'b0;
      end else if (key_clr) begin
         r_par     <= 1'b0;
         r_key_err <= 1'b0;
      end else begin
         if (w_accept && w_full)
            r_par <= key_sdi;
         if (w_idle_like && load_start)
            r_key_err <= 1'b0;
         else if (r_state == ST_CHECK && w_chk_bad)
            r_key_err <= 1'b1;
      end
   end

   assign key_err = r_key_err;
`else
   assign w_last    = (w_cnt == CNT_W'(KEY_W - 1));
   assign w_chk_bad = 1'b0;
   assign key_err   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (key_clr) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: if (load_start) w_state_nxt = ST_SHIFT;
            ST_SHIFT: begin
               if (w_accept && w_last)
                  w_state_nxt = ST_CHECK;
`ifndef RLL_KEY_PARITY_EN
               else if (w_full)
                  w_state_nxt = ST_CHECK;
`endif
            end
            ST_CHECK: w_state_nxt = w_chk_bad ? ST_ERR : ST_DONE;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_rdy    = (r_state == ST_SHIFT);
      w_busy   = (r_state == ST_SHIFT) || (r_state == ST_CHECK);
      w_sh_clr = key_clr || (w_idle_like && load_start);
      w_commit = (r_state == ST_CHECK) && !w_chk_bad && !key_clr;
   end

   // key_out only moves on a passing CHECK, key_clr or reset, never mid-shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_out   <= '0;
         r_key_valid <= 1'b0;
      end else if (key_clr) begin
         r_key_out   <= '0;
         r_key_valid <= 1'b0;
      end else if (w_commit) begin
         r_key_out   <= w_shadow;
         r_key_valid <= 1'b1;
      end
   end

   assign key_sdi_ready = w_rdy;
   assign busy          = w_busy;
   assign key_out       = r_key_out;
   assign key_valid     = r_key_valid;

endmodule

// File: tb/tb_rll_key_loader.sv
// Randomized self-checking bench for rll_key_loader against a transaction-level key model.
module tb_rll_key_loader;

   localparam int KW = 32;
`ifdef RLL_KEY_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NB = KW + PAR;

   logic          clk;
   logic          rst_n;
   logic          load_start;
   logic          key_clr;
   logic          key_sdi;
   logic          key_sdi_valid;
   logic          key_sdi_ready;
   logic [KW-1:0] key_out;
   logic          key_valid;
   logic          busy;
   logic          key_err;

   int n_tests;
   int n_fail;

   logic [KW-1:0] m_key;
   logic          m_valid;
   logic          m_err;

   rll_key_loader #(.KEY_W(KW), .CNT_W(6)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_start    (load_start),
      .key_clr       (key_clr),
      .key_sdi       (key_sdi),
      .key_sdi_valid (key_sdi_valid),
      .key_sdi_ready (key_sdi_ready),
      .key_out       (key_out),
      .key_valid     (key_valid),
      .busy          (busy),
      .key_err       (key_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the summary, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic good_par(input logic [KW-1:0] k);
      return (PAR != 0) ? (^k) : 1'b0;
   endfunction

   // Reference: a load passes when the whole stream has even weight (always, without parity).
   task automatic model_load(input logic [KW-1:0] k, input logic pbit);
      logic ok;
      ok = (PAR == 0) || (((^k) ^ pbit) == 1'b0);
      m_err = 1'b0;
      if (ok) begin
         m_key   = k;
         m_valid = 1'b1;
      end else begin
         m_err = 1'b1;
      end
   endtask

   task automatic model_zero();
      m_key   = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
   endtask

   // Entered and left at posedge+1. mode 0: continuous, 1: toggling (starting low), 2: random.
   task automatic feed(input logic [KW-1:0] k, input logic pbit, input int mode,
                       input int stop_after, input int mid_start_at,
                       output int accepted, output int cycles, output logic moved);
      logic [KW:0] bits;
      logic        rdy;
      logic        v;
      logic        tog;
      bits     = {pbit, k};
      moved    = 1'b0;
      tog      = 1'b0;
      accepted = 0;
      cycles   = 0;
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      while (accepted < stop_after && cycles < 1000) begin
         rdy = key_sdi_ready;
         case (mode)
            0:       v = 1'b1;
            1:       v = tog;
            default: v = 1'($urandom_range(0, 1));
         endcase
         tog           = ~tog;
         key_sdi_valid = v;
         key_sdi       = bits[accepted];
         load_start    = (accepted == mid_start_at);
         if (key_out !== m_key) moved = 1'b1;
         @(posedge clk); #1;
         load_start = 1'b0;
         if (v && rdy) accepted++;
         cycles++;
      end
      key_sdi_valid = 1'b0;
      key_sdi       = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      load_start = 1'b0; key_clr = 1'b0; key_sdi = 1'b0; key_sdi_valid = 1'b0;
      model_zero();
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (key_out !== m_key) begin n_fail++; $display("FAIL reset_key_out: got %h required %h", key_out, m_key); end
      n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b required 0", key_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
      n_tests++; if (key_err !== 1'b0) begin n_fail++; $display("FAIL reset_key_err: got %b required 0", key_err); end
      n_tests++; if (key_sdi_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", key_sdi_ready); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

`ifdef RLL_KEY_PARITY_EN
   task automatic test_parity_err();
      int acc, cyc;
      logic mv;
      logic [KW-1:0] k;
      k = 32'hA5A5_5A5A;
      feed(k, 1'b1, 0, NB, -1, acc, cyc, mv);
      @(posedge clk); #1;
      model_load(k, 1'b1);
      n_tests++; if (key_err !== 1'b1) begin n_fail++; $display("FAIL parerr_key_err: got %b required 1", key_err); end
      n_tests++; if (key_out !== m_key) begin n_fail++; $display("FAIL parerr_key_out: got %h required %h", key_out, m_key); end
      n_tests++; if (key_valid !== m_valid) begin n_fail++; $display("FAIL parerr_key_valid: got %b required %b", key_valid, m_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL parerr_busy: got %b required 0", busy); end
   endtask
`endif

   task automatic test_basic();
      int acc, cyc, lat;
      logic mv;
      logic [KW-1:0] k;
      k = 32'hA5A5_5A5A;
      feed(k, good_par(k), 0, NB, -1, acc, cyc, mv);
      lat = 1 + cyc;
      while (key_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      model_load(k, good_par(k));
      n_tests++; if (lat !== NB + 2) begin n_fail++; $display("FAIL basic_latency: got %0d required %0d", lat, NB + 2); end
      n_tests++; if (key_out !== m_key) begin n_fail++; $display("FAIL basic_key_out: got %h required %h", key_out, m_key); end
      n_tests++; if (key_valid !== m_valid) begin n_fail++; $display("FAIL basic_key_valid: got %b required %b", key_valid, m_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b required 0", busy); end
      n_tests++; if (key_err !== m_err) begin n_fail++; $display("FAIL basic_key_err: got %b required %b", key_err, m_err); end
   endtask

   task automatic test_toggle_valid();
      int acc, cyc;
      logic mv;
      logic [KW-1:0] k;
      k = 32'hFFFF_FFFF;
      feed(k, good_par(k), 1, NB, -1, acc, cyc, mv);
      @(posedge clk); #1;
      model_load(k, good_par(k));
      n_tests++; if (acc !== NB) begin n_fail++; $display("FAIL toggle_accepted: got %0d required %0d", acc, NB); end
      n_tests++; if (cyc !== 2 * NB) begin n_fail++; $display("FAIL toggle_window: got %0d required %0d", cyc, 2 * NB); end
      n_tests++; if (key_out !== m_key) begin n_fail++; $display("FAIL toggle_key_out: got %h required %h", key_out, m_key); end
      n_tests++; if (key_valid !== m_valid) begin n_fail++; $display("FAIL toggle_key_valid: got %b required %b", key_valid, m_valid); end
      n_tests++; if (mv !== 1'b0) begin n_fail++; $display("FAIL toggle_key_out_moved: got %b required 0", mv); end
   endtask

   task automatic test_clr_abort();
      int acc, cyc;
      logic mv;
      logic [KW-1:0] k;
      k = 32'h1234_5678;
      feed(k, good_par(k), 0, NB, -1, acc, cyc, mv);
      @(posedge clk); #1;
      model_load(k, good_par(k));
      n_tests++; if (key_out !== m_key) begin n_fail++; $display("FAIL clr_precommit: got %h required %h", key_out, m_key); end
      k = $urandom;
      feed(k, good_par(k), 0, 10, -1, acc, cyc, mv);
      key_clr = 1'b1;
      @(posedge clk); #1;
      key_clr = 1'b0;
      model_zero();
      n_tests++; if (key_out !== m_key) begin n_fail++; $display("FAIL clr_key_out: got %h required %h", key_out, m_key); end
      n_tests++; if (key_valid !== m_valid) begin n_fail++; $display("FAIL clr_key_valid: got %b required %b", key_valid, m_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b required 0", busy); end
      n_tests++; if (key_sdi_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready: got %b required 0", key_sdi_ready); end
      n_tests++; if (key_err !== m_err) begin n_fail++; $display("FAIL clr_key_err: got %b required %b", key_err, m_err); end
   endtask

   task automatic test_start_ignored();
      int acc, cyc;
      logic mv;
      logic [KW-1:0] k;
      k = $urandom;
      feed(k, good_par(k), 0, NB, 13, acc, cyc, mv);
      @(posedge clk); #1;
      model_load(k, good_par(k));
      n_tests++; if (acc !== NB) begin n_fail++; $display("FAIL midstart_accepted: got %0d required %0d", acc, NB); end
      n_tests++; if (key_out !== m_key) begin n_fail++; $display("FAIL midstart_key_out: got %h required %h", key_out, m_key); end
      n_tests++; if (key_valid !== m_valid) begin n_fail++; $display("FAIL midstart_key_valid: got %b required %b", key_valid, m_valid); end
   endtask

   task automatic test_random();
      int acc, cyc;
      logic mv;
      logic [KW-1:0] k;
      logic pb;
      for (int i = 0; i < 6; i++) begin
         k  = $urandom;
         pb = good_par(k);
         if (PAR != 0 && $urandom_range(0, 2) == 0) pb = ~pb;
         feed(k, pb, 2, NB, -1, acc, cyc, mv);
         n_tests++; if (mv !== 1'b0) begin n_fail++; $display("FAIL rand%0d_key_out_moved: got %b required 0", i, mv); end
         @(posedge clk); #1;
         model_load(k, pb);
         n_tests++; if (acc !== NB) begin n_fail++; $display("FAIL rand%0d_accepted: got %0d required %0d", i, acc, NB); end
         n_tests++; if (key_out !== m_key) begin n_fail++; $display("FAIL rand%0d_key_out: got %h required %h", i, key_out, m_key); end
         n_tests++; if (key_valid !== m_valid) begin n_fail++; $display("FAIL rand%0d_key_valid: got %b required %b", i, key_valid, m_valid); end
         n_tests++; if (key_err !== m_err) begin n_fail++; $display("FAIL rand%0d_key_err: got %b required %b", i, key_err, m_err); end
         n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_busy: got %b required 0", i, busy); end
      end
   endtask

   task automatic test_reset_mid();
      int acc, cyc;
      logic mv;
      logic [KW-1:0] k;
      k = $urandom;
      feed(k, good_par(k), 0, 20, -1, acc, cyc, mv);
      #2 rst_n = 1'b0;
      #1;
      model_zero();
      n_tests++; if (key_out !== m_key) begin n_fail++; $display("FAIL rstmid_key_out: got %h required %h", key_out, m_key); end
      n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_key_valid: got %b required 0", key_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b required 0", busy); end
      n_tests++; if (key_sdi_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b required 0", key_sdi_ready); end
      n_tests++; if (key_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_key_err: got %b required 0", key_err); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      k = 32'h0000_0001;
      feed(k, good_par(k), 0, NB, -1, acc, cyc, mv);
      @(posedge clk); #1;
      model_load(k, good_par(k));
      n_tests++; if (key_out !== m_key) begin n_fail++; $display("FAIL rstmid_reload_key_out: got %h required %h", key_out, m_key); end
      n_tests++; if (key_valid !== m_valid) begin n_fail++; $display("FAIL rstmid_reload_valid: got %b required %b", key_valid, m_valid); end
      n_tests++; if (mv !== 1'b0) begin n_fail++; $display("FAIL rstmid_reload_moved: got %b required 0", mv); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
`ifdef RLL_KEY_PARITY_EN
      test_parity_err();
`endif
      test_basic();
      test_toggle_valid();
      test_clr_abort();
      test_start_ignored();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
